// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution frame sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int K_DEFAULT = 3;

  // Width of the line-buffer slot select; K>=2 so at least one bit.
  function automatic int clog2_k(input int k);
    return (k <= 2) ? 1 : $clog2(k);
  endfunction

endpackage

// File: rtl/conv_pos_cnt.sv
// Raster position counter: column, row and circular line-buffer slot,
// advanced once per accepted pixel.
module conv_pos_cnt
  import conv_pkg::*;
#(
  parameter int XB = 10,
  parameter int YB = 10,
  parameter int K  = K_DEFAULT,
  parameter int SB = clog2_k(K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [XB-1:0] width,
  output logic [XB-1:0] col,
  output logic [YB-1:0] row,
  output logic [SB-1:0] sel
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
      sel <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
      sel <= '0;
    end else if (en) begin
      if (col == width - XB'(1)) begin
        col <= '0;
        row <= row + YB'(1);
        sel <= (sel == SB'(K - 1)) ? '0 : sel + SB'(1);
      end else begin
        col <= col + XB'(1);
      end
    end
  end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer: pops pixels into K circular line buffers and emits one
// window token per complete KxK window, stalling intake on token backpressure.
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int XB = 10,
  parameter int YB = 10,
  parameter int K  = K_DEFAULT,
  localparam int SB = clog2_k(K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XB-1:0] cfg_width,
  input  logic [YB-1:0] cfg_height,
  input  logic          px_valid,
  output logic          px_ready,
  output logic          lb_wr_en,
  output logic [SB-1:0] lb_wr_sel,
  output logic [XB-1:0] lb_wr_addr,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [XB-1:0] win_col,
  output logic [YB-1:0] win_row,
  output logic          busy,
  output logic          frame_done,
  output logic          cfg_err
);

  state_t        state;
  logic [XB-1:0] w_reg;
  logic [YB-1:0] h_reg;
  logic [XB-1:0] col;
  logic [YB-1:0] row;
  logic [SB-1:0] sel;

  logic accept;
  logic start_ok;
  logic drain_done;
  logic in_window;
  logic last_px;

  // A pending token blocks intake unless it is consumed this same cycle,
  // so a new token can never overwrite an unaccepted one.
  assign px_ready   = (state == RUN) & (~win_valid | win_ready);
  assign accept     = px_valid & px_ready;
  assign lb_wr_en   = accept;
  assign lb_wr_addr = col;
  assign lb_wr_sel  = sel;
  assign busy       = (state != IDLE);

  assign start_ok   = (state == IDLE) & start &
                      (cfg_width >= XB'(K)) & (cfg_height >= YB'(K));
  assign drain_done = (state == DRAIN) & (~win_valid | win_ready);
  assign in_window  = (row >= YB'(K - 1)) & (col >= XB'(K - 1));
  assign last_px    = (col == w_reg - XB'(1)) & (row == h_reg - YB'(1));

  conv_pos_cnt #(
    .XB(XB),
    .YB(YB),
    .K (K),
    .SB(SB)
  ) u_pos (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_ok | drain_done),
    .en   (accept),
    .width(w_reg),
    .col  (col),
    .row  (row),
    .sel  (sel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      w_reg      <= '0;
      h_reg      <= '0;
      win_valid  <= 1'b0;
      win_col    <= '0;
      win_row    <= '0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              w_reg <= cfg_width;
              h_reg <= cfg_height;
              state <= RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept && last_px) state <= DRAIN;
        end
        DRAIN: begin
          if (drain_done) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Token register: the pixel completing a window loads its top-left corner.
      if (accept && in_window) begin
        win_valid <= 1'b1;
        win_col   <= col - XB'(K - 1);
        win_row   <= row - YB'(K - 1);
      end else if (win_valid && win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Randomized scoreboard bench for conv_frame_ctrl: a frame-level model queues
// expected line-buffer writes and window tokens; a monitor checks every transfer.
module tb_conv_frame_ctrl;

  localparam int XB = 10;
  localparam int YB = 10;
  localparam int K  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [XB-1:0] cfg_width = '0;
  logic [YB-1:0] cfg_height = '0;
  logic          px_valid = 1'b0;
  logic          px_ready;
  logic          lb_wr_en;
  logic [1:0]    lb_wr_sel;
  logic [XB-1:0] lb_wr_addr;
  logic          win_valid;
  logic          win_ready = 1'b0;
  logic [XB-1:0] win_col;
  logic [YB-1:0] win_row;
  logic          busy;
  logic          frame_done;
  logic          cfg_err;

  conv_frame_ctrl #(.XB(XB), .YB(YB), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_width (cfg_width),
    .cfg_height(cfg_height),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .lb_wr_en  (lb_wr_en),
    .lb_wr_sel (lb_wr_sel),
    .lb_wr_addr(lb_wr_addr),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_col   (win_col),
    .win_row   (win_row),
    .busy      (busy),
    .frame_done(frame_done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_q[$];   // sel*65536 + addr
  int tok_q[$];  // row*65536 + col
  int exp_frames  = 0;
  int exp_cfg_err = 0;
  int frames_seen = 0;
  int cyc = 0;
  int last_hs = -10;
  bit held = 1'b0;
  int hold_col, hold_row;
  int m_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name, input int a, input int b);
    checks++;
    errors++;
    $display("FAIL %s: observed %0d/%0d, nothing expected (t=%0t)", name, a, b, $time);
  endtask

  // Reference model: raster-order writes into slot row%K, and one token per
  // top-left corner of every KxK window fitting inside the frame.
  task automatic push_frame(input int w, input int h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        wr_q.push_back((r % K) * 65536 + c);
    for (int y = 0; y <= h - K; y++)
      for (int x = 0; x <= w - K; x++)
        tok_q.push_back(y * 65536 + x);
    exp_frames++;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      cyc++;
      if (lb_wr_en) begin
        if (wr_q.size() == 0) bad("unexpected_write", lb_wr_sel, lb_wr_addr);
        else begin
          m_e = wr_q.pop_front();
          chk("wr_sel", lb_wr_sel, m_e / 65536);
          chk("wr_addr", lb_wr_addr, m_e % 65536);
        end
      end
      if (win_valid) begin
        if (held) begin
          chk("stall_col_stable", win_col, hold_col);
          chk("stall_row_stable", win_row, hold_row);
        end
        if (!win_ready) begin
          chk("px_ready_during_stall", px_ready, 0);
          held = 1'b1;
          hold_col = win_col;
          hold_row = win_row;
        end else begin
          held = 1'b0;
          last_hs = cyc;
          $display("token col=%0d row=%0d", win_col, win_row);
          if (tok_q.size() == 0) bad("unexpected_token", win_col, win_row);
          else begin
            m_e = tok_q.pop_front();
            chk("tok_col", win_col, m_e % 65536);
            chk("tok_row", win_row, m_e / 65536);
          end
        end
      end else begin
        held = 1'b0;
      end
      if (frame_done) begin
        if (exp_frames == 0) bad("unexpected_frame_done", cyc, 0);
        else begin
          chk("done_tokens_left", tok_q.size(), 0);
          chk("done_writes_left", wr_q.size(), 0);
          chk("done_after_last_hs", cyc, last_hs + 1);
          exp_frames--;
          frames_seen++;
          $display("frame_done at cycle %0d", cyc);
        end
      end
      if (cfg_err) begin
        if (exp_cfg_err == 0) bad("unexpected_cfg_err", cyc, 0);
        else exp_cfg_err--;
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_px_ready", px_ready, 0);
    chk("rst_lb_wr_en", lb_wr_en, 0);
    chk("rst_lb_wr_sel", lb_wr_sel, 0);
    chk("rst_lb_wr_addr", lb_wr_addr, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_col", win_col, 0);
    chk("rst_win_row", win_row, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
  endtask

  task automatic do_start(input int w, input int h);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_width = XB'(w);
    cfg_height = YB'(h);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input int vpct, input int rpct,
                           input bit stall, input bit mid_start);
    int target;
    int n;
    int stall_cnt;
    target = frames_seen + 1;
    n = 0;
    stall_cnt = 0;
    $display("frame W=%0d H=%0d valid%%=%0d ready%%=%0d", w, h, vpct, rpct);
    push_frame(w, h);
    do_start(w, h);
    while (frames_seen < target && n < 5000) begin
      px_valid  = ($urandom_range(1, 100) <= vpct);
      win_ready = ($urandom_range(1, 100) <= rpct);
      if (stall && stall_cnt < 5) begin
        win_ready = 1'b0;
        if (win_valid) stall_cnt++;
      end
      if (mid_start && n == 6) begin
        start = 1'b1;
        cfg_width = XB'(2);
        cfg_height = YB'(2);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    if (frames_seen < target) chk("frame_timeout", frames_seen, target);
    if (stall) chk("stall_cycles_applied", stall_cnt, 5);
    px_valid = 1'b0;
    win_ready = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int n;
    #2 rst = 1'b0;
    #18;
    check_reset_vals();
    @(negedge clk); rst = 1'b1;

    // Basic 4x4 frame, free flow.
    run_frame(4, 4, 100, 100, 1'b0, 1'b0);
    // Token backpressure on the first window.
    run_frame(4, 4, 100, 100, 1'b1, 1'b0);

    // Rejected configurations.
    px_valid = 1'b1;
    exp_cfg_err = 1;
    do_start(2, 8);
    @(negedge clk); #1;
    chk("cfg_err_w2_seen", exp_cfg_err, 0);
    chk("cfg_err_busy", busy, 0);
    chk("cfg_err_px_ready", px_ready, 0);
    exp_cfg_err = 1;
    do_start(8, 2);
    @(negedge clk); #1;
    chk("cfg_err_h2_seen", exp_cfg_err, 0);
    chk("cfg_err_lb_wr_en", lb_wr_en, 0);
    px_valid = 1'b0;

    // Start during a frame is ignored.
    run_frame(5, 4, 80, 80, 1'b0, 1'b1);

    // Reset in the middle of a frame, at row 2 column 1.
    push_frame(5, 5);
    do_start(5, 5);
    px_valid = 1'b1;
    win_ready = 1'b1;
    n = 0;
    while (!(lb_wr_en && lb_wr_sel == 2'd2 && lb_wr_addr == XB'(1)) && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    chk("reach_row2_col1", n < 200, 1);
    rst = 1'b0;
    #1;
    check_reset_vals();
    wr_q.delete();
    tok_q.delete();
    exp_frames = 0;
    held = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_frame_done", frame_done, 0);
    px_valid = 1'b0;
    win_ready = 1'b0;
    @(negedge clk); rst = 1'b1;
    run_frame(4, 4, 100, 100, 1'b0, 1'b0);

    // Random gaps and backpressure.
    run_frame(7, 5, 60, 70, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      run_frame($urandom_range(3, 9), $urandom_range(3, 8), 50, 50, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("final_tokens_left", tok_q.size(), 0);
    chk("final_writes_left", wr_q.size(), 0);
    chk("final_frames_pending", exp_frames, 0);
    chk("final_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
